// File: rtl/mips32_mem_pkg.sv
// Shared types, widths and address helpers for the mips32 data-memory block.
package mips32_mem_pkg;

  localparam int BE_W        = 4;
  localparam int WORD_W      = 32;
  localparam int MAX_LATENCY = 7;
  localparam int MAX_ADDR_W  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Word index of a byte address (address widened to MAX_ADDR_W by the caller).
  function automatic logic [MAX_ADDR_W-1:0] word_index(input logic [MAX_ADDR_W-1:0] addr);
    return addr >> 2;
  endfunction

  // A word access is misaligned when either of the two low address bits is set.
  function automatic logic misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/mips32_dmem_array.sv
// Word-organised storage with byte-lane writes and a combinational read port.
module mips32_dmem_array
  import mips32_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Update only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mips32_dmem_ctrl.sv
// Request/response data-memory controller: wait states, byte lanes, error
// flagging and saturating access counters around mips32_dmem_array.
module mips32_dmem_ctrl
  import mips32_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       wr_count,
  output logic [31:0]       rd_count
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  if (LATENCY < 0 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $fatal(1, "mips32_dmem_ctrl: LATENCY must be in 0..7");
  end
  if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $fatal(1, "mips32_dmem_ctrl: DEPTH_WORDS must be a power of two >= 4");
  end
  if (ADDR_W < 2 || ADDR_W > MAX_ADDR_W) begin : g_bad_addr_w
    $fatal(1, "mips32_dmem_ctrl: ADDR_W must be in 2..64");
  end

  state_t              state, state_nxt;
  logic [2:0]          wcnt, wcnt_nxt;
  logic                cap_we;
  logic [ADDR_W-1:0]   cap_addr;
  logic [WORD_W-1:0]   cap_wdata;
  logic [BE_W-1:0]     cap_be;
  logic                accept, do_access, acc_we, acc_err, arr_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [WORD_W-1:0]   acc_wdata, arr_rdata;
  logic [BE_W-1:0]     acc_be;
  logic [MAX_ADDR_W-1:0] addr_ext, widx;
  logic [31:0]         wr_cnt, rd_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign req_ready = (state != WAIT);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  // With zero wait states the access uses the live request on the accepting
  // edge; otherwise it uses the captured request when the wait count expires.
  assign do_access = (LATENCY == 0) ? accept : (state == WAIT && wcnt == 3'd0);
  assign acc_we    = (LATENCY == 0) ? req_we    : cap_we;
  assign acc_addr  = (LATENCY == 0) ? req_addr  : cap_addr;
  assign acc_wdata = (LATENCY == 0) ? req_wdata : cap_wdata;
  assign acc_be    = (LATENCY == 0) ? req_be    : cap_be;

  assign addr_ext = MAX_ADDR_W'(acc_addr);
  assign widx     = word_index(addr_ext);
  assign acc_err  = misaligned(addr_ext[1:0]) || (widx >= MAX_ADDR_W'(DEPTH_WORDS));
  assign arr_we   = do_access && acc_we && !acc_err;

  mips32_dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (acc_be),
    .idx   (widx[IDX_W-1:0]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  // State register and wait counter; reset drops any pending access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      wcnt  <= 3'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Next-state logic: accept in IDLE/RESP, count down in WAIT.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            wcnt_nxt  = 3'(LATENCY - 1);
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (wcnt == 3'd0) state_nxt = RESP;
        else              wcnt_nxt  = wcnt - 3'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request on acceptance so the requester may move on.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we    <= req_we;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
      cap_be    <= req_be;
    end
  end

  // Response data, error status and counters update on the access edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
    end else if (do_access) begin
      rsp_err <= acc_err;
      if (acc_err) begin
        rsp_rdata <= '0;
      end else if (acc_we) begin
        wr_cnt <= sat_inc(wr_cnt);
      end else begin
        rsp_rdata <= arr_rdata;
        rd_cnt    <= sat_inc(rd_cnt);
      end
    end
  end

  assign wr_count = wr_cnt;
  assign rd_count = rd_cnt;

endmodule

// File: tb/tb_mips32_dmem_ctrl.sv
// Self-checking bench: three controller instances (LATENCY 2, 0, 3) against a
// word-array reference model with saturating counters.
module tb_mips32_dmem_ctrl;

  localparam int N     = 3;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset_n   [N];
  logic        req_valid [N];
  logic        req_we    [N];
  logic [31:0] req_addr  [N];
  logic [31:0] req_wdata [N];
  logic [3:0]  req_be    [N];
  logic        req_ready [N];
  logic        rsp_valid [N];
  logic [31:0] rsp_rdata [N];
  logic        rsp_err   [N];
  logic [31:0] wr_count  [N];
  logic [31:0] rd_count  [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    mips32_dmem_ctrl #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     ((g == 0) ? 2 : (g == 1) ? 0 : 3),
      .ADDR_W      (32)
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n[g]),
      .req_valid (req_valid[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .req_ready (req_ready[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .wr_count  (wr_count[g]),
      .rd_count  (rd_count[g])
    );
  end

  always #5 clk = ~clk;

  // Reference model
  logic [31:0] mem_m [N][DEPTH];
  logic [31:0] wr_m [N];
  logic [31:0] rd_m [N];

  // Pending stimulus
  logic        tq_we    [$];
  logic [31:0] tq_addr  [$];
  logic [31:0] tq_wdata [$];
  logic [3:0]  tq_be    [$];

  int checks = 0;
  int errors = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 0 : 3;
  endfunction

  task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be);
    tq_we.push_back(we);
    tq_addr.push_back(addr);
    tq_wdata.push_back(wdata);
    tq_be.push_back(be);
  endtask

  // Issue the queued transactions back-to-back on instance k and check each response.
  task automatic run_seq(input int k);
    int n;
    int e;
    logic exp_err;
    logic [31:0] exp_rd;
    logic [31:0] widx;
    n = tq_addr.size();
    @(negedge clk);
    for (int j = 0; j < n; j++) begin
      checks++;
      if (req_ready[k] !== 1'b1) begin
        errors++;
        $display("FAIL ready_before_issue k=%0d txn=%0d got %b exp 1", k, j, req_ready[k]);
      end
      req_valid[k] = 1'b1;
      req_we[k]    = tq_we[j];
      req_addr[k]  = tq_addr[j];
      req_wdata[k] = tq_wdata[j];
      req_be[k]    = tq_be[j];
      exp_err = (tq_addr[j][1:0] != 2'b00) || ((tq_addr[j] >> 2) >= 32'(DEPTH));
      widx    = tq_addr[j] >> 2;
      exp_rd  = 32'h0;
      if (!exp_err) begin
        if (tq_we[j]) begin
          for (int b = 0; b < 4; b++)
            if (tq_be[j][b]) mem_m[k][widx][8*b +: 8] = tq_wdata[j][8*b +: 8];
          if (wr_m[k] != 32'hFFFF_FFFF) wr_m[k] = wr_m[k] + 1;
        end else begin
          exp_rd = mem_m[k][widx];
          if (rd_m[k] != 32'hFFFF_FFFF) rd_m[k] = rd_m[k] + 1;
        end
      end
      @(posedge clk);
      for (e = 1; e <= 12; e++) begin
        @(negedge clk);
        if (rsp_valid[k] === 1'b1) break;
        req_valid[k] = 1'b0;
        checks++;
        if (req_ready[k] !== 1'b0) begin
          errors++;
          $display("FAIL ready_in_wait k=%0d txn=%0d got %b exp 0", k, j, req_ready[k]);
        end
        @(posedge clk);
      end
      checks++;
      if (e != lat_of(k) + 1) begin
        errors++;
        $display("FAIL latency k=%0d txn=%0d got %0d exp %0d", k, j, e, lat_of(k) + 1);
      end
      checks++;
      if (rsp_err[k] !== exp_err) begin
        errors++;
        $display("FAIL rsp_err k=%0d addr=%h got %b exp %b", k, tq_addr[j], rsp_err[k], exp_err);
      end
      if (exp_err || !tq_we[j]) begin
        checks++;
        if (rsp_rdata[k] !== exp_rd) begin
          errors++;
          $display("FAIL rsp_rdata k=%0d addr=%h got %h exp %h", k, tq_addr[j], rsp_rdata[k], exp_rd);
        end
      end
      checks++;
      if (wr_count[k] !== wr_m[k] || rd_count[k] !== rd_m[k]) begin
        errors++;
        $display("FAIL counters k=%0d got wr=%h rd=%h exp wr=%h rd=%h",
                 k, wr_count[k], rd_count[k], wr_m[k], rd_m[k]);
      end
    end
    req_valid[k] = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid[k] !== 1'b0) begin
      errors++;
      $display("FAIL rsp_single_pulse k=%0d got %b exp 0", k, rsp_valid[k]);
    end
    tq_we.delete();
    tq_addr.delete();
    tq_wdata.delete();
    tq_be.delete();
  endtask

  task automatic test_reset;
    for (int k = 0; k < N; k++) reset_n[k] = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0 || rsp_err[k] !== 1'b0 ||
          rsp_rdata[k] !== 32'h0 || wr_count[k] !== 32'h0 || rd_count[k] !== 32'h0) begin
        errors++;
        $display("FAIL reset_state k=%0d got ready=%b vld=%b err=%b rdata=%h wr=%h rd=%h exp 1 0 0 0 0 0",
                 k, req_ready[k], rsp_valid[k], rsp_err[k], rsp_rdata[k], wr_count[k], rd_count[k]);
      end
    end
    for (int k = 0; k < N; k++) reset_n[k] = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset k=%0d got ready=%b vld=%b exp 1 0", k, req_ready[k], rsp_valid[k]);
      end
    end
  endtask

  task automatic test_write_read;
    push(1'b1, 32'd252, 32'd210, 4'hF);
    push(1'b0, 32'd252, 32'h0, 4'h0);
    run_seq(0);
  endtask

  task automatic test_byte_lanes;
    push(1'b1, 32'd8, 32'h1122_3344, 4'hF);
    push(1'b1, 32'd8, 32'hAABB_CCDD, 4'b0101);
    push(1'b0, 32'd8, 32'h0, 4'hF);
    push(1'b1, 32'd12, 32'hDEAD_BEEF, 4'b0000);
    push(1'b0, 32'd12, 32'h0, 4'h0);
    run_seq(0);
  endtask

  task automatic test_errors;
    push(1'b1, 32'd0, 32'h0BAD_F00D, 4'hF);
    push(1'b0, 32'd6, 32'h0, 4'h0);
    push(1'b1, 32'd1024, 32'hFFFF_FFFF, 4'hF);
    push(1'b1, 32'd2, 32'h1234_5678, 4'hF);
    push(1'b0, 32'd0, 32'h0, 4'h0);
    push(1'b0, 32'd1024, 32'h0, 4'h0);
    run_seq(0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) push(1'b1, 32'(4 * i), $urandom(), 4'hF);
    run_seq(1);
    wr_m[1] = wr_count[1];
    checks++;
    if (rd_count[1] !== 32'd0) begin
      errors++;
      $display("FAIL b2b_rd_before k=1 got %0d exp 0", rd_count[1]);
    end
    for (int i = 0; i < 8; i++) push(1'b0, 32'(4 * (7 - i)), 32'h0, 4'h0);
    run_seq(1);
    checks++;
    if (rd_count[1] !== 32'd8) begin
      errors++;
      $display("FAIL b2b_rd_count k=1 got %0d exp 8", rd_count[1]);
    end
  endtask

  task automatic test_reset_mid_txn;
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 32'd0;
    req_wdata[2] = 32'd5;
    req_be[2]    = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    checks++;
    if (req_ready[2] !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait_ready k=2 got %b exp 0", req_ready[2]);
    end
    #2 reset_n[2] = 1'b0;
    #1;
    wr_m[2] = 32'h0;
    rd_m[2] = 32'h0;
    checks++;
    if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b1 || wr_count[2] !== 32'h0 || rd_count[2] !== 32'h0) begin
      errors++;
      $display("FAIL async_reset k=2 got vld=%b ready=%b wr=%h rd=%h exp 0 1 0 0",
               rsp_valid[2], req_ready[2], wr_count[2], rd_count[2]);
    end
    @(negedge clk);
    reset_n[2] = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (rsp_valid[2] !== 1'b0 || wr_count[2] !== 32'h0) begin
      errors++;
      $display("FAIL dropped_access k=2 got vld=%b wr=%h exp 0 0", rsp_valid[2], wr_count[2]);
    end
    push(1'b0, 32'd0, 32'h0, 4'h0);
    run_seq(2);
  endtask

  task automatic test_random(input int k, input int n);
    for (int j = 0; j < n; j++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'(($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(250, 255)) << 2);
      else if (r == 7) a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
      else if (r == 8) a = 32'($urandom_range(256, 1023) << 2);
      else             a = $urandom() & 32'hFFFF_FFFC;
      push(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)));
    end
    run_seq(k);
  endtask

  task automatic test_saturation;
    @(negedge clk);
    force g_dut[0].u_dut.wr_cnt = 32'hFFFF_FFFE;
    #1;
    release g_dut[0].u_dut.wr_cnt;
    wr_m[0] = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) push(1'b1, 32'(16 + 4 * i), $urandom(), 4'hF);
    run_seq(0);
    checks++;
    if (wr_count[0] !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wr_saturate k=0 got %h exp ffffffff", wr_count[0]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      reset_n[k]   = 1'b0;
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = 32'h0;
      req_wdata[k] = 32'h0;
      req_be[k]    = 4'h0;
      wr_m[k]      = 32'h0;
      rd_m[k]      = 32'h0;
      for (int w = 0; w < DEPTH; w++) mem_m[k][w] = 32'h0;
    end
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_errors();
    test_back_to_back();
    test_reset_mid_txn();
    test_random(0, 40);
    test_random(2, 40);
    test_random(1, 40);
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips32_dmem_ctrl.md
Name: mips32_dmem_ctrl

Overview:
Parametrised data-memory block for the mips32 pipeline. It replaces the zero-wait, word-only data memory with a request/response handshake, a programmable wait-state count, byte-lane writes, error flagging and access counters. It sits between the pipeline's memory stage and the data RAM, and is also used as the bench data memory for stall and latency testing.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of two, minimum 4
LATENCY, 2, wait states between acceptance and response; legal range 0..7
ADDR_W, 32, request byte-address width

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  byte address
req_wdata  in  32  write data
req_be  in  4  byte enables; bit i selects bits [8i+7:8i]; ignored on reads
req_ready  out  1  block can accept a request this cycle
rsp_valid  out  1  one-cycle response/acknowledge pulse
rsp_rdata  out  32  read data; held until the next response
rsp_err  out  1  error status, qualified by rsp_valid
wr_count  out  32  completed successful writes, saturating
rd_count  out  32  completed successful reads, saturating

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wr_count=0, rd_count=0. Array contents are not cleared by reset; they are zero at time zero.
- FSM states: IDLE, WAIT, RESP.
- req_ready is 1 in IDLE and RESP, and 0 in WAIT.
- Acceptance occurs on an edge where req_valid=1 and req_ready=1. On acceptance, req_we, req_addr, req_wdata and req_be are captured. The requester may change its inputs afterwards.
- LATENCY=0: the access is performed on the accepting edge. Next state is RESP.
- LATENCY=N>0: next state is WAIT with wcnt=N-1.
  - In WAIT, each edge decrements wcnt.
  - On the edge where wcnt==0, the access is performed and the FSM enters RESP.
- Result: rsp_valid is high for exactly one cycle, beginning LATENCY+1 edges after the accepting edge.
- RESP:
  - rsp_valid=1.
  - A request accepted in RESP starts the next transaction back-to-back, giving a sustained throughput of one transaction per LATENCY+1 cycles.
  - Otherwise next state is IDLE.
- Access:
  - Word index = addr >> 2.
  - Write: only enabled byte lanes are updated. be=4'b0000 is acknowledged and counted but changes nothing.
  - Read: rsp_rdata = full word.
- Error: rsp_err=1 if addr[1:0]!=0 or word index >= DEPTH_WORDS.
  - On error, there is no array write, rsp_rdata=0, and no counter increments.
  - rsp_valid still pulses.
- Counters:
  - wr_count/rd_count increment on the access edge of a successful write or read.
  - They saturate at 32'hFFFF_FFFF, with no wrap.
- Read-after-write: a read accepted in RESP of a write to the same word returns the new data, because the write was committed on the earlier edge.
- Reset mid-transaction: the pending access is dropped; no partial write occurs.
- rsp_err and rsp_rdata values outside rsp_valid are don't-care for checking. The RTL holds the last values.

Decomposition:
- Package mips32_mem_pkg:
  - state enum {IDLE, WAIT, RESP}
  - BE_W=4, WORD_W=32, MAX_LATENCY=7
  - function word_index(addr)
  - function misaligned(addr)
- Sub-module mips32_dmem_array: DEPTH_WORDS×32 byte-lane storage with one access port (we, be[3:0], idx, wdata, rdata). Its read is combinational from idx. The controller holds the FSM, wait counter, error check and counters.
- Elaboration check: LATENCY outside 0..7 or non-power-of-two DEPTH_WORDS is a fatal error.

Test Plan:
1. LATENCY=2: write 210 to addr 252 with be=4'hF, then read addr 252. Expect rsp_valid exactly 3 edges after each acceptance, rsp_rdata=210, rsp_err=0, wr_count=1, rd_count=1.
2. Byte lanes: write 32'h11223344 to addr 8 with be=F, then write 32'hAABBCCDD to addr 8 with be=4'b0101. A read of addr 8 returns 32'h11BB33DD.
3. Errors: read addr 6 → rsp_err=1, rsp_rdata=0. Write addr 1024 with DEPTH_WORDS=256 → rsp_err=1, array unchanged, counters unchanged.
4. Back-to-back, LATENCY=0: req_valid held for 8 reads → one rsp_valid per cycle after the first edge, 8 responses, rd_count=8, req_ready never low.
5. LATENCY=3: assert reset_n=0 asynchronously while in WAIT for a write of 5 to addr 0. Expect immediate rsp_valid=0, req_ready=1, counters 0. A subsequent read of addr 0 returns 0.
6. Saturation: force wr_count to 32'hFFFF_FFFE, then perform 3 successful writes → wr_count=32'hFFFF_FFFF.
